// File: rtl/ppu_palette_pkg.sv
`default_nettype none
// ============================================================================
// ppu_palette_pkg : palette widths, controller state encoding, address mirror
// Revision: 1.0
// ============================================================================
package ppu_palette_pkg;

  localparam int PAL_ADDR_W = 5;
  localparam int COLOR_W    = 6;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_ACK  = 2'd2
  } pal_state_t;

  // Sprite entry 0 of each palette aliases the matching background entry.
  function automatic logic [PAL_ADDR_W-1:0] pal_mirror(input logic [PAL_ADDR_W-1:0] addr);
    return (addr[4] && (addr[1:0] == 2'b00)) ? (addr & 5'h0F) : addr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/palette_ram.sv
`default_nettype none
// ============================================================================
// palette_ram : 32 x 6 single-port synchronous RAM, registered read (read-first)
// Revision: 1.0
// ============================================================================
module palette_ram
  import ppu_palette_pkg::*;
(
  input  logic                  clk,
  input  logic [PAL_ADDR_W-1:0] addr,
  input  logic                  we,
  input  logic [COLOR_W-1:0]    wdata,
  output logic [COLOR_W-1:0]    rdata
);

  logic [COLOR_W-1:0] mem [2**PAL_ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/palette_ram_ctrl.sv
`default_nettype none
// ============================================================================
// palette_ram_ctrl : palette RAM owner; post-reset clear, pixel/CPU arbitration
// Revision: 1.0
// ============================================================================
module palette_ram_ctrl
  import ppu_palette_pkg::*;
#(
  parameter logic [COLOR_W-1:0] INIT_COLOR = 6'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pix_valid,
  input  logic [PAL_ADDR_W-1:0] pix_index,
  output logic                  color_valid,
  output logic [COLOR_W-1:0]    color,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [PAL_ADDR_W-1:0] cpu_addr,
  input  logic [COLOR_W-1:0]    cpu_wdata,
  output logic                  cpu_ack,
  output logic [COLOR_W-1:0]    cpu_rdata,
  output logic                  init_busy
);

  pal_state_t            state;
  logic [PAL_ADDR_W-1:0] clr_addr;
  logic                  pix_s1;
  logic                  pix_init_s1;
  logic                  grant;
  logic [PAL_ADDR_W-1:0] ram_addr;
  logic                  ram_we;
  logic [COLOR_W-1:0]    ram_wdata;
  logic [COLOR_W-1:0]    ram_rdata;

  assign grant = rst_n && (state == ST_IDLE) && cpu_req && !pix_valid;

  // Port mux: clear counter, then pixel (always wins), then granted CPU access.
  always_comb begin
    ram_addr  = pal_mirror(cpu_addr);
    ram_we    = 1'b0;
    ram_wdata = cpu_wdata;
    if (state == ST_INIT) begin
      ram_addr  = pal_mirror(clr_addr);
      ram_we    = rst_n;
      ram_wdata = INIT_COLOR;
    end else if (pix_valid) begin
      ram_addr = (pix_index[1:0] == 2'b00) ? '0 : pal_mirror(pix_index);
    end else if (grant) begin
      ram_we = cpu_we;
    end
  end

  palette_ram u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_INIT;
      clr_addr    <= '0;
      init_busy   <= 1'b1;
      pix_s1      <= 1'b0;
      pix_init_s1 <= 1'b0;
      color_valid <= 1'b0;
      color       <= '0;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= '0;
    end else begin
      // Lookups taken during the clear bypass the RAM and report the fill value.
      pix_s1      <= pix_valid;
      pix_init_s1 <= (state == ST_INIT);
      color_valid <= pix_s1;
      if (pix_s1) begin
        color <= pix_init_s1 ? INIT_COLOR : ram_rdata;
      end
      cpu_ack <= (state == ST_ACK);
      if (state == ST_ACK) begin
        cpu_rdata <= ram_rdata;
      end
      case (state)
        ST_INIT: begin
          clr_addr <= clr_addr + PAL_ADDR_W'(1);
          if (clr_addr == '1) begin
            state     <= ST_IDLE;
            init_busy <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (grant) begin
            state <= ST_ACK;
          end
        end
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_palette_ram_ctrl.sv
`default_nettype none
// ============================================================================
// tb_palette_ram_ctrl : table vectors plus scoreboard for palette_ram_ctrl
// Revision: 1.0
// ============================================================================
module tb_palette_ram_ctrl;
  import ppu_palette_pkg::*;

  localparam logic [5:0] INIT_C = 6'h21;
  localparam logic [1:0] OP_W = 2'd0;
  localparam logic [1:0] OP_R = 2'd1;
  localparam logic [1:0] OP_P = 2'd2;

  typedef struct {
    logic [1:0] op;
    logic [4:0] addr;
    logic [5:0] wdata;
    logic [5:0] exp;
  } vec_t;

  typedef struct packed {
    logic       is_read;
    logic [5:0] data;
  } cpu_exp_t;

  logic clk = 1'b0;
  logic rst_n, pix_valid, color_valid, cpu_req, cpu_we, cpu_ack, init_busy;
  logic [4:0] pix_index, cpu_addr;
  logic [5:0] color, cpu_wdata, cpu_rdata;

  logic [5:0] pix_q[$];
  cpu_exp_t   cpu_q[$];
  vec_t       vecs[20];
  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  palette_ram_ctrl #(.INIT_COLOR(INIT_C)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_valid  (pix_valid),
    .pix_index  (pix_index),
    .color_valid(color_valid),
    .color      (color),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .init_busy  (init_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock, sample just after the edge and retire scoreboard entries.
  task automatic tick();
    logic [5:0] pe;
    cpu_exp_t   ce;
    @(posedge clk);
    #1;
    cyc++;
    if (color_valid) begin
      checks++;
      if (pix_q.size() == 0) begin
        errors++;
        $display("FAIL pix_extra: color=%h with no lookup pending (cycle %0d)", color, cyc);
      end else begin
        pe = pix_q.pop_front();
        if (color !== pe) begin
          errors++;
          $display("FAIL pix_color: got %h expected %h (cycle %0d)", color, pe, cyc);
        end
      end
    end
    if (cpu_ack) begin
      checks++;
      if (cpu_q.size() == 0) begin
        errors++;
        $display("FAIL cpu_extra_ack: rdata=%h with no request pending (cycle %0d)", cpu_rdata, cyc);
      end else begin
        ce = cpu_q.pop_front();
        if (ce.is_read && (cpu_rdata !== ce.data)) begin
          errors++;
          $display("FAIL cpu_rdata: got %h expected %h (cycle %0d)", cpu_rdata, ce.data, cyc);
        end
      end
    end
  endtask

  task automatic cpu_op(input logic we, input logic [4:0] addr, input logic [5:0] wdata,
                        input logic [5:0] exp);
    int waited = 0;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_q.push_back('{!we, exp});
    do begin
      tick();
      waited++;
    end while (!cpu_ack && waited < 50);
    check("cpu_latency", 32'(waited), 32'd2);
    cpu_req = 1'b0;
  endtask

  task automatic pix_lookup(input logic [4:0] idx, input logic [5:0] exp);
    pix_valid = 1'b1;
    pix_index = idx;
    pix_q.push_back(exp);
    tick();
    pix_valid = 1'b0;
    tick();
  endtask

  // Release reset with a CPU read held and one lookup issued mid-clear.
  task automatic release_clear();
    rst_n    = 1'b1;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 5'h05;
    cpu_q.push_back('{1'b1, INIT_C});
    for (int i = 1; i <= 32; i++) begin
      pix_valid = (i == 10);
      pix_index = 5'h07;
      if (i == 10) pix_q.push_back(INIT_C);
      tick();
      check("init_busy", 32'(init_busy), 32'(i < 32));
      check("init_no_ack", 32'(cpu_ack), 32'd0);
    end
    pix_valid = 1'b0;
    tick();
    check("init_grant_edge_ack", 32'(cpu_ack), 32'd0);
    tick();
    check("first_ack_after_init", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic read_all_init();
    for (int a = 0; a < 32; a++) cpu_op(1'b0, 5'(a), 6'h00, INIT_C);
  endtask

  task automatic check_reset_values();
    check("rst_color_valid", 32'(color_valid), 32'd0);
    check("rst_color", 32'(color), 32'd0);
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_init_busy", 32'(init_busy), 32'd1);
  endtask

  initial begin
    vecs[0]  = '{OP_W, 5'h10, 6'h2A, 6'h00};
    vecs[1]  = '{OP_R, 5'h00, 6'h00, 6'h2A};
    vecs[2]  = '{OP_P, 5'h10, 6'h00, 6'h2A};
    vecs[3]  = '{OP_W, 5'h13, 6'h15, 6'h00};
    vecs[4]  = '{OP_R, 5'h03, 6'h00, INIT_C};
    vecs[5]  = '{OP_R, 5'h13, 6'h00, 6'h15};
    vecs[6]  = '{OP_W, 5'h00, 6'h30, 6'h00};
    vecs[7]  = '{OP_W, 5'h05, 6'h0C, 6'h00};
    vecs[8]  = '{OP_P, 5'h04, 6'h00, 6'h30};
    vecs[9]  = '{OP_P, 5'h18, 6'h00, 6'h30};
    vecs[10] = '{OP_P, 5'h1C, 6'h00, 6'h30};
    vecs[11] = '{OP_P, 5'h05, 6'h00, 6'h0C};
    vecs[12] = '{OP_W, 5'h1C, 6'h3F, 6'h00};
    vecs[13] = '{OP_R, 5'h0C, 6'h00, 6'h3F};
    vecs[14] = '{OP_P, 5'h0C, 6'h00, 6'h30};
    vecs[15] = '{OP_P, 5'h13, 6'h00, 6'h15};
    vecs[16] = '{OP_W, 5'h14, 6'h07, 6'h00};
    vecs[17] = '{OP_R, 5'h04, 6'h00, 6'h07};
    vecs[18] = '{OP_P, 5'h11, 6'h00, INIT_C};
    vecs[19] = '{OP_R, 5'h1C, 6'h00, 6'h3F};

    rst_n = 1'b0; pix_valid = 1'b0; pix_index = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) tick();
    check_reset_values();
    release_clear();
    read_all_init();

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_W:    cpu_op(1'b1, vecs[i].addr, vecs[i].wdata, 6'h00);
        OP_R:    cpu_op(1'b0, vecs[i].addr, 6'h00, vecs[i].exp);
        default: pix_lookup(vecs[i].addr, vecs[i].exp);
      endcase
    end

    // Pixel latency and hold.
    pix_valid = 1'b1; pix_index = 5'h05; pix_q.push_back(6'h0C);
    tick();
    check("lat_not_yet", 32'(color_valid), 32'd0);
    pix_valid = 1'b0;
    tick();
    check("lat_valid", 32'(color_valid), 32'd1);
    tick();
    check("lat_drop", 32'(color_valid), 32'd0);
    check("lat_hold", 32'(color), 32'h0C);

    // Request withdrawn while blocked by pixels: no access, no ack.
    pix_valid = 1'b1; pix_index = 5'h05; pix_q.push_back(6'h0C);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'h05; cpu_wdata = 6'h3F;
    tick();
    cpu_req = 1'b0; pix_q.push_back(6'h0C);
    tick();
    pix_valid = 1'b0;
    repeat (3) begin
      tick();
      check("cancel_no_ack", 32'(cpu_ack), 32'd0);
    end
    pix_lookup(5'h05, 6'h0C);

    // Pixel priority over a waiting CPU read.
    for (int c = 0; c < 10; c++) begin
      pix_valid = 1'b1; pix_index = 5'h05; pix_q.push_back(6'h0C);
      if (c == 2) begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h05;
        cpu_q.push_back('{1'b1, 6'h0C});
      end
      tick();
      check("prio_no_ack", 32'(cpu_ack), 32'd0);
    end
    pix_valid = 1'b0;
    tick();
    check("prio_grant_edge", 32'(cpu_ack), 32'd0);
    tick();
    check("prio_ack", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("prio_single_ack", 32'(cpu_ack), 32'd0);
    end

    // Eight back-to-back writes with cpu_req held throughout.
    begin
      int last = 0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'h08; cpu_wdata = 6'h10;
      cpu_q.push_back('{1'b0, 6'h00});
      for (int k = 0; k < 8; k++) begin
        int waited = 0;
        do begin
          tick();
          waited++;
        end while (!cpu_ack && waited < 20);
        check("b2b_ack_seen", 32'(cpu_ack), 32'd1);
        if (k > 0) check("b2b_spacing", 32'(cyc - last), 32'd2);
        last = cyc;
        if (k < 7) begin
          cpu_addr  = 5'(8 + k + 1);
          cpu_wdata = 6'(16 + k + 1);
          cpu_q.push_back('{1'b0, 6'h00});
        end else begin
          cpu_req = 1'b0;
        end
      end
      tick();
    end
    cpu_op(1'b0, 5'h09, 6'h00, 6'h11);
    pix_lookup(5'h0F, 6'h17);
    cpu_op(1'b0, 5'h1C, 6'h00, 6'h14);

    // Reset arriving on the cycle after a grant drops the pending ack.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'h01; cpu_wdata = 6'h3C;
    tick();
    check("rst_mid_pre_ack", 32'(cpu_ack), 32'd0);
    rst_n = 1'b0; cpu_req = 1'b0;
    tick();
    check_reset_values();
    repeat (2) begin
      tick();
      check("rst_mid_no_ack", 32'(cpu_ack), 32'd0);
    end
    release_clear();
    read_all_init();

    checks++;
    if (pix_q.size() != 0 || cpu_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: pix=%0d cpu=%0d entries never produced", pix_q.size(), cpu_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/palette_ram_ctrl.md
# palette_ram_ctrl

Palette memory controller for the PPU colour path. It owns the 32-entry × 6-bit palette RAM and arbitrates its single port between the pixel pipeline and CPU register accesses. It also applies NES-style address mirroring and backdrop substitution, and clears the RAM after reset. Its `color` output feeds the system-palette RGB converter directly.

## Interface
Parameters:
- `INIT_COLOR`, default `6'h00`: value written to every entry during post-reset clear.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; synchronous, active-low
- `pix_valid`  in  1  renderer requests a colour lookup this cycle
- `pix_index`  in  5  palette index: bit4 = sprite/bg, [3:2] = palette, [1:0] = pixel
- `color_valid`  out  1  `color` is valid
- `color`  out  6  colour index {R[1:0],G[1:0],B[1:0]} to the system palette
- `cpu_req`  in  1  CPU access request, held until `cpu_ack`
- `cpu_we`  in  1  1 = write, 0 = read; stable while `cpu_req` is high
- `cpu_addr`  in  5  palette address; stable while `cpu_req` is high
- `cpu_wdata`  in  6  write data
- `cpu_ack`  out  1  one-cycle completion pulse
- `cpu_rdata`  out  6  read data, valid while `cpu_ack` = 1
- `init_busy`  out  1  clear sequence in progress

## Operation
- FSM states: INIT, IDLE, ACK.
  - INIT: 5-bit counter `clr_addr` starts at 0 and writes `INIT_COLOR` to one address per cycle, 0 through 31. INIT → IDLE after address 31 is written (32 cycles).
  - IDLE: CPU grant when `cpu_req` = 1 and `pix_valid` = 0. The grant performs the RAM access that cycle, then IDLE → ACK.
  - ACK: `cpu_ack` = 1 for exactly one cycle. No new CPU grant in this state, so a still-held `cpu_req` is never served twice. ACK → IDLE unconditionally.
- Address mirroring applies to all ports and to the clear counter. Effective address = `a & 5'h0F` when `a[4]` = 1 and `a[1:0]` = 0. For example, 0x10/0x14/0x18/0x1C alias 0x00/0x04/0x08/0x0C.
- Backdrop substitution: for pixel lookups with `pix_index[1:0]` = 0, effective address = 0x00. CPU accesses are not substituted.
- Priority: the pixel pipeline always owns the port when `pix_valid` = 1. The CPU waits, with no timeout; the renderer guarantees blanking gaps.
- Pixel lookups are served in every state. During INIT they return `color` = `INIT_COLOR` without reading RAM.
- CPU requests are not granted during INIT.
- Unused `color` bits: none. All 6 bits are driven from RAM.

## Timing
- Reset values:
  - `color_valid` = 0, `color` = 0
  - `cpu_ack` = 0, `cpu_rdata` = 0
  - `init_busy` = 1
  - state = INIT, `clr_addr` = 0
- `init_busy` is 1 during reset and for 32 cycles after `rst_n` rises. It falls the same cycle the state enters IDLE.
- Pixel latency is 1 cycle: `pix_valid` sampled at edge N gives `color_valid`/`color` registered at edge N+1. `color_valid` = 0 whenever `pix_valid` was 0 the previous cycle. The last `color` is held.
- CPU access:
  - Grant at edge N; `cpu_ack` and `cpu_rdata` are registered at edge N+1.
  - A write is visible to any lookup sampled at edge N+1 or later.
  - Minimum request-to-ack is 1 cycle.
- Simultaneous `pix_valid` and `cpu_req`: the pixel lookup wins and the CPU grant is deferred to the first cycle with `pix_valid` = 0 while in IDLE.
- `cpu_req` dropped before ack: the request is cancelled with no access. If already granted, the ack still pulses.
- Reset mid-operation: state returns to INIT, any pending ack is discarded, and the clear restarts at address 0.

## Structure
- Package `ppu_palette_pkg` holds:
  - `PAL_ADDR_W` = 5, `COLOR_W` = 6
  - state encoding (INIT, IDLE, ACK)
  - `pal_mirror(addr)` function
- Sub-module `palette_ram`: 32×6 single-port synchronous RAM with one address, `we`, `wdata`, and registered `rdata`. The controller owns the address/`we` mux (clear counter / pixel / CPU), the FSM, and the output registers.

## Test plan
- Reset clear: release `rst_n`, wait 32 cycles → `init_busy` falls on cycle 32. CPU reads of all 32 addresses return `INIT_COLOR`; `cpu_ack` is never asserted during INIT.
- Write/read and mirroring: CPU writes 0x2A to 0x10 → CPU read of 0x00 returns 0x2A, and `pix_index` = 0x10 yields `color` = 0x2A one cycle later. Write 0x15 to 0x13 → read of 0x03 is unchanged (no mirror).
- Backdrop: write 0x30 to 0x00 and 0x0C to 0x05; pixel lookups of 0x04, 0x18, 0x1C → `color` = 0x30 each. Lookup of 0x05 → 0x0C.
- Priority: `pix_valid` = 1 for 10 cycles with `cpu_req` raised at cycle 2 → no `cpu_ack` until the cycle after `pix_valid` drops. Then exactly one ack pulse, even with `cpu_req` held 3 more cycles.
- Back-to-back: 8 CPU writes with `cpu_req` held continuously → 8 acks, each exactly 2 cycles apart (grant, ACK).
- Reset mid-access: assert `rst_n` = 0 the cycle of a CPU grant → no `cpu_ack` afterward, `init_busy` = 1, and a full 32-cycle clear runs again.
